param_risc_core: RTL and testbench
==================================

PARAM_RISC_CORE -- requirements
Module: param_risc_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register and ALU width, at least 4.
REQ-002 SHALL have parameter NREGS, default 4: register count, a power of 2, at least 2. RW = clog2(NREGS).
REQ-003 SHALL have parameter IMEM_DEPTH, default 32: instruction words, a power of 2. AW = clog2(IMEM_DEPTH).
REQ-004 SHALL have parameter IMM_W, default 8: immediate field width, at least max(2*RW, AW). INSTR_W = 3+RW+IMM_W.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 run  in  1  1 = pipeline advances; 0 = PC, IR, registers and flags hold.
REQ-008 imem_we  in  1  instruction-memory write strobe.
REQ-009 imem_addr  in  AW  write address.
REQ-010 imem_wdata  in  INSTR_W  write data.
REQ-011 regs_flat  out  NREGS*DATA_W  register i at bits [i*DATA_W +: DATA_W].
REQ-012 pc_out  out  AW  current fetch PC.
REQ-013 flag_z, flag_c  out  1 each  zero and carry/borrow flags.
REQ-014 halted  out  1  core has executed HALT.
REQ-015 retire  out  1  one-cycle pulse per executed non-bubble instruction.

Function
REQ-016 Instruction layout SHALL be: opcode [INSTR_W-1 -: 3], rd next RW bits, imm in the low IMM_W bits. rs1 = imm[2RW-1:RW]; rs2 = imm[RW-1:0]; target = imm[AW-1:0].
REQ-017 Opcodes SHALL be:
- 000 LDI: rd <= zero-extended imm, truncated to DATA_W.
- 001 ADD, 010 SUB, 011 AND, 100 XOR: rd <= rs1 op rs2, modulo 2^DATA_W.
- 101 BZ: branch to target if flag_z = 1.
- 110 JMP: branch to target unconditionally.
- 111 HALT.
REQ-018 ALU ops SHALL update flag_z (result == 0). ADD and SUB SHALL update flag_c: carry-out for ADD, borrow for SUB. AND and XOR SHALL clear flag_c. LDI, BZ, JMP and HALT SHALL leave the flags unchanged.
REQ-019 The pipeline SHALL have two stages: fetch (IR <= imem[pc], ir_valid <= 1, pc <= pc+1) and execute of IR, overlapped.
REQ-020 The first register write after reset release SHALL be visible 2 cycles after reset deasserts with run = 1.
REQ-021 PC SHALL wrap from IMEM_DEPTH-1 to 0.
REQ-022 A taken BZ or JMP SHALL set pc <= target and ir_valid <= 0, giving a 1-cycle bubble. The bubble SHALL NOT retire or change any state.
REQ-023 A not-taken BZ SHALL cost no extra cycles.
REQ-024 A read-after-write between back-to-back instructions SHALL read the written value. Register write and the next execute are on separate edges, so no forwarding is needed.
REQ-025 HALT SHALL set halted = 1, clear ir_valid and freeze pc. The core stays halted until reset; run is ignored while halted.
REQ-026 An imem write SHALL take effect on the next edge. If a write and a fetch hit the same address in the same cycle, the fetch SHALL return the old word.
REQ-027 imem writes SHALL be accepted regardless of run, halted or reset.

Reset
REQ-028 On reset, at any time: pc, all registers, flag_z, flag_c, halted, retire and ir_valid SHALL be 0.
REQ-029 Reset SHALL NOT clear imem contents.
REQ-030 Reset mid-branch or mid-halt SHALL discard all in-flight state.

Structure
REQ-031 The opcode enumeration, the field-offset functions and the INSTR_W derivation SHALL live in the shared package param_risc_pkg.
REQ-032 The combinational ALU (op, a, b -> result, z, c) SHALL be the sub-module param_risc_alu. The register file and imem SHALL stay inline.

Verification (default parameters)
REQ-033 Load LDI r1,#200; LDI r2,#100; ADD r3,r1,r2; run -> r3 = 44, flag_c = 1, flag_z = 0; retire pulses 3 times.
REQ-034 Load LDI r0,#5; SUB r1,r0,r0; BZ 7; LDI r2,#9; imem[7] = LDI r3,#1 -> r1 = 0, flag_z = 1, r2 stays 0, r3 = 1; one bubble cycle with retire = 0.
REQ-035 Fill imem with 32 LDI r0,#k (k = 0..31), run 40 cycles -> pc_out wraps 31 -> 0, and r0 follows k modulo the wrap.
REQ-036 Load HALT at address 2 and run 10 cycles -> halted = 1, pc_out frozen at 3, no further retire; assert reset -> all outputs 0.
REQ-037 Deassert run for 5 cycles mid-program -> registers, pc_out and flags hold; the program resumes with identical final results.
REQ-038 Assert reset while a JMP is in execute -> pc_out = 0 on the next cycle and execution restarts at address 0; imem is unchanged.

Source files
------------

// File: rtl/param_risc_pkg.sv
// Shared ISA definitions for the param_risc core.
// Opcode encoding and instruction field placement helpers.
package param_risc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LDI  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_XOR  = 3'b100,
        OP_BZ   = 3'b101,
        OP_JMP  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    function automatic int instr_w(input int rw, input int imm_w);
        return OP_W + rw + imm_w;
    endfunction

    function automatic int op_lsb(input int rw, input int imm_w);
        return imm_w + rw;
    endfunction

    function automatic int rd_lsb(input int imm_w);
        return imm_w;
    endfunction

    function automatic int rs1_lsb(input int rw);
        return rw;
    endfunction

    function automatic logic is_alu(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR};
    endfunction

endpackage

// File: rtl/param_risc_if.sv
// Instruction-memory write port of the param_risc core.
// The loader drives it as master, the core listens as slave.
interface param_risc_if #(
    parameter int AW      = 5,
    parameter int INSTR_W = 13
);
    logic               imem_we;
    logic [AW-1:0]      imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/param_risc_alu.sv
// Combinational ALU: ADD/SUB report carry/borrow,
// AND/XOR report carry 0; z flags a zero result.
module param_risc_alu
    import param_risc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c
);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        c      = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): {c, result} = sum;
            (op == OP_SUB): {c, result} = diff;
            (op == OP_AND): result = a & b;
            (op == OP_XOR): result = a ^ b;
            default: ;
        endcase
    end

    assign z = (result == '0);
endmodule

// File: rtl/param_risc_core.sv
// Two-stage (fetch / execute) parameterised RISC core
// with inline register file and instruction memory.
module param_risc_core
    import param_risc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NREGS      = 4,
    parameter int IMEM_DEPTH = 32,
    parameter int IMM_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    param_risc_if.slave                   bus,
    output logic [NREGS*DATA_W-1:0]       regs_flat,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc_out,
    output logic                          flag_z,
    output logic                          flag_c,
    output logic                          halted,
    output logic                          retire
);
    localparam int RW      = $clog2(NREGS);
    localparam int AW      = $clog2(IMEM_DEPTH);
    localparam int INSTR_W = instr_w(RW, IMM_W);
    localparam int OP_LSB  = op_lsb(RW, IMM_W);
    localparam int RD_LSB  = rd_lsb(IMM_W);
    localparam int RS1_LSB = rs1_lsb(RW);

    logic [INSTR_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0]  regs [NREGS];

    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic [AW-1:0]      pc;

    opcode_e            op;
    logic [RW-1:0]      rd;
    logic [RW-1:0]      rs1;
    logic [RW-1:0]      rs2;
    logic [IMM_W-1:0]   imm;
    logic [AW-1:0]      target;
    logic               advance;
    logic               exec;
    logic               taken;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_z;
    logic               alu_c;

    assign op     = opcode_e'(ir[OP_LSB +: OP_W]);
    assign rd     = ir[RD_LSB +: RW];
    assign imm    = ir[IMM_W-1:0];
    assign rs1    = imm[RS1_LSB +: RW];
    assign rs2    = imm[RW-1:0];
    assign target = imm[AW-1:0];

    assign advance = run && !halted;
    assign exec    = advance && ir_valid;
    assign taken   = exec && ((op == OP_JMP) || ((op == OP_BZ) && flag_z));

    param_risc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (regs[rs1]),
        .b      (regs[rs2]),
        .result (alu_res),
        .z      (alu_z),
        .c      (alu_c)
    );

    // Loader writes bypass reset/run; a same-cycle fetch sees the old word.
    always_ff @(posedge clk) begin
        if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            halted   <= 1'b0;
            retire   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            retire <= exec;
            if (exec && (op == OP_HALT)) begin
                halted   <= 1'b1;
                ir_valid <= 1'b0;
            end else if (taken) begin
                pc       <= target;
                ir_valid <= 1'b0;
            end else if (advance) begin
                ir       <= imem[pc];
                ir_valid <= 1'b1;
                pc       <= pc + AW'(1);
            end
            if (exec) begin
                unique case (1'b1)
                    (op == OP_LDI): regs[rd] <= DATA_W'(imm);
                    is_alu(op): begin
                        regs[rd] <= alu_res;
                        flag_z   <= alu_z;
                        flag_c   <= alu_c;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    assign pc_out = pc;
endmodule

// File: tb/tb_param_risc_core.sv
// Self-checking bench for param_risc_core (default parameters)
// against an instruction-level reference model with cycle costs.
module tb_param_risc_core;

    localparam int AW  = 5;
    localparam int INW = 13;

    localparam int T_LDI  = 0;
    localparam int T_ADD  = 1;
    localparam int T_SUB  = 2;
    localparam int T_AND  = 3;
    localparam int T_XOR  = 4;
    localparam int T_BZ   = 5;
    localparam int T_JMP  = 6;
    localparam int T_HALT = 7;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           run = 1'b0;
    logic [31:0]    regs_flat;
    logic [AW-1:0]  pc_out;
    logic           flag_z;
    logic           flag_c;
    logic           halted;
    logic           retire;

    always #5 clk = ~clk;

    param_risc_if #(.AW(AW), .INSTR_W(INW)) bus ();

    param_risc_core #(
        .DATA_W(8), .NREGS(4), .IMEM_DEPTH(32), .IMM_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .bus       (bus),
        .regs_flat (regs_flat),
        .pc_out    (pc_out),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .halted    (halted),
        .retire    (retire)
    );

    int tests = 0;
    int fails = 0;
    int cyc;
    int ret_cnt;
    int halt_at;
    logic [INW-1:0] prog [32];

    int m_r [4];
    int m_z, m_c, m_h, m_pc, m_n, m_hc;

    function automatic logic [INW-1:0] enc(input int op, input int rd, input int imm);
        return INW'((op << 10) | (rd << 8) | (imm & 255));
    endfunction

    function automatic logic [7:0] reg_of(input int i);
        return regs_flat[i*8 +: 8];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (retire === 1'b1) ret_cnt++;
        if (halted === 1'b1 && halt_at < 0) halt_at = cyc;
    endtask

    task automatic fill_halt;
        for (int i = 0; i < 32; i++) prog[i] = enc(T_HALT, 0, 0);
    endtask

    task automatic load_prog;
        reset = 1'b1;
        run   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.imem_we    = 1'b1;
            bus.imem_addr  = AW'(i);
            bus.imem_wdata = prog[i];
            tick;
        end
        bus.imem_we = 1'b0;
        tick;
    endtask

    task automatic release_core;
        reset   = 1'b0;
        run     = 1'b1;
        cyc     = 0;
        ret_cnt = 0;
        halt_at = -1;
    endtask

    task automatic run_until_halt(input int budget);
        for (int i = 0; i < budget && halted !== 1'b1; i++) tick;
    endtask

    task automatic gen_random;
        int sel, rd, imm, t;
        for (int i = 0; i < 31; i++) begin
            sel = $urandom_range(0, 9);
            rd  = $urandom_range(0, 3);
            imm = $urandom_range(0, 255);
            if (sel >= 3 && sel <= 6) prog[i] = enc(sel - 2, rd, imm);
            else if (sel == 7 || sel == 8) begin
                t = $urandom_range(31, i + 1);
                imm = ($urandom_range(0, 7) << 5) | t;
                prog[i] = enc(sel == 7 ? T_BZ : T_JMP, rd, imm);
            end else prog[i] = enc(T_LDI, rd, imm);
        end
        prog[31] = enc(T_HALT, 0, 0);
    endtask

    // ISA-level model: one cycle per executed instruction, one extra per taken branch.
    task automatic model_run(input int max_cyc);
        int a, cm, op, rd, imm, x, y, r;
        logic [INW-1:0] w;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_z = 0; m_c = 0; m_h = 0; m_n = 0; m_hc = -1;
        cm = 1; a = 0; m_pc = 1;
        while (cm < max_cyc && m_h == 0) begin
            cm++;
            w   = prog[a];
            op  = int'(w[12:10]);
            rd  = int'(w[9:8]);
            imm = int'(w[7:0]);
            x   = m_r[(imm >> 2) & 3];
            y   = m_r[imm & 3];
            m_n++;
            if (op == T_HALT) begin
                m_h = 1; m_hc = cm; m_pc = (a + 1) % 32;
            end else if (op == T_JMP || (op == T_BZ && m_z == 1)) begin
                a = imm % 32; m_pc = a;
                if (cm < max_cyc) begin cm++; m_pc = (a + 1) % 32; end
            end else begin
                if (op == T_LDI) m_r[rd] = imm;
                else if (op != T_BZ) begin
                    case (op)
                        T_ADD: begin r = x + y; m_c = (r > 255) ? 1 : 0; end
                        T_SUB: begin r = x - y; m_c = (x < y) ? 1 : 0; end
                        T_AND: begin r = x & y; m_c = 0; end
                        default: begin r = x ^ y; m_c = 0; end
                    endcase
                    r = r & 255;
                    m_z = (r == 0) ? 1 : 0;
                    m_r[rd] = r;
                end
                a = (a + 1) % 32; m_pc = (a + 1) % 32;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; run = 1'b1;
        tick; tick;
        tests++; if (regs_flat !== 32'd0) begin fails++; $display("FAIL reset_regs got %h want 0", regs_flat); end
        tests++; if (pc_out !== 5'd0) begin fails++; $display("FAIL reset_pc got %0d want 0", pc_out); end
        tests++; if (flag_z !== 1'b0 || flag_c !== 1'b0) begin fails++; $display("FAIL reset_flags got z%b c%b want 0", flag_z, flag_c); end
        tests++; if (halted !== 1'b0 || retire !== 1'b0) begin fails++; $display("FAIL reset_status got h%b r%b want 0", halted, retire); end
    endtask

    task automatic test_add_carry;
        fill_halt;
        prog[0] = enc(T_LDI, 1, 200);
        prog[1] = enc(T_LDI, 2, 100);
        prog[2] = enc(T_ADD, 3, (1 << 2) | 2);
        load_prog; release_core;
        repeat (4) tick;
        tests++; if (reg_of(3) !== 8'd44) begin fails++; $display("FAIL add_r3 got %0d want 44", reg_of(3)); end
        tests++; if (flag_c !== 1'b1 || flag_z !== 1'b0) begin fails++; $display("FAIL add_flags got z%b c%b want z0 c1", flag_z, flag_c); end
        tests++; if (ret_cnt != 3) begin fails++; $display("FAIL add_retire got %0d want 3", ret_cnt); end
        run_until_halt(20);
        model_run(1000);
        tests++; if (halt_at != m_hc) begin fails++; $display("FAIL add_halt_cycle got %0d want %0d", halt_at, m_hc); end
    endtask

    task automatic test_bz;
        int bub;
        fill_halt;
        prog[0] = enc(T_LDI, 0, 5);
        prog[1] = enc(T_SUB, 1, 0);
        prog[2] = enc(T_BZ, 0, 7);
        prog[3] = enc(T_LDI, 2, 9);
        prog[7] = enc(T_LDI, 3, 1);
        load_prog; release_core;
        bub = 0;
        for (int i = 0; i < 30 && halted !== 1'b1; i++) begin
            tick;
            if (cyc >= 2 && retire !== 1'b1) bub++;
        end
        model_run(1000);
        tests++; if (reg_of(1) !== 8'd0 || flag_z !== 1'b1) begin fails++; $display("FAIL bz_r1 got %0d z%b want 0 z1", reg_of(1), flag_z); end
        tests++; if (reg_of(2) !== 8'd0) begin fails++; $display("FAIL bz_r2 got %0d want 0", reg_of(2)); end
        tests++; if (reg_of(3) !== 8'd1) begin fails++; $display("FAIL bz_r3 got %0d want 1", reg_of(3)); end
        tests++; if (bub != 1) begin fails++; $display("FAIL bz_bubbles got %0d want 1", bub); end
        tests++; if (halt_at != m_hc) begin fails++; $display("FAIL bz_halt_cycle got %0d want %0d", halt_at, m_hc); end
    endtask

    task automatic test_wrap;
        int em [32];
        int fetched [52];
        for (int k = 0; k < 32; k++) begin prog[k] = enc(T_LDI, 0, k); em[k] = k; end
        load_prog; release_core;
        for (int e = 1; e <= 50; e++) begin
            fetched[e] = em[(e - 1) % 32];
            if (e == 11) begin
                bus.imem_we = 1'b1; bus.imem_addr = 5'd10; bus.imem_wdata = enc(T_LDI, 0, 99);
            end
            tick;
            bus.imem_we = 1'b0;
            if (e == 11) em[10] = 99;
            tests++; if (pc_out !== AW'(e % 32)) begin fails++; $display("FAIL wrap_pc e%0d got %0d want %0d", e, pc_out, e % 32); end
            if (e >= 2) begin
                tests++; if (reg_of(0) !== 8'(fetched[e - 1])) begin fails++; $display("FAIL wrap_r0 e%0d got %0d want %0d", e, reg_of(0), fetched[e - 1]); end
            end
        end
    endtask

    task automatic test_halt;
        fill_halt;
        prog[0] = enc(T_LDI, 0, 7);
        prog[1] = enc(T_LDI, 1, 3);
        load_prog; release_core;
        repeat (10) tick;
        tests++; if (halted !== 1'b1 || pc_out !== 5'd3) begin fails++; $display("FAIL halt_state got h%b pc%0d want h1 pc3", halted, pc_out); end
        tests++; if (ret_cnt != 3 || retire !== 1'b0) begin fails++; $display("FAIL halt_retire got %0d want 3", ret_cnt); end
        tests++; if (halt_at != 4) begin fails++; $display("FAIL halt_cycle got %0d want 4", halt_at); end
        run = 1'b0; tick; run = 1'b1; tick;
        tests++; if (halted !== 1'b1 || pc_out !== 5'd3 || reg_of(0) !== 8'd7) begin fails++; $display("FAIL halt_sticky got h%b pc%0d want h1 pc3", halted, pc_out); end
        reset = 1'b1; tick;
        tests++; if (regs_flat !== 32'd0 || pc_out !== 5'd0 || halted !== 1'b0 || retire !== 1'b0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            fails++; $display("FAIL halt_reset got regs%h pc%0d h%b r%b want all 0", regs_flat, pc_out, halted, retire);
        end
    endtask

    task automatic test_run_stall;
        int s_r [4];
        int s_z, s_c, s_pc, want_hc;
        gen_random;
        model_run(6);
        s_r = m_r; s_z = m_z; s_c = m_c; s_pc = m_pc;
        load_prog; release_core;
        repeat (6) tick;
        run = 1'b0;
        repeat (5) begin
            tick;
            for (int i = 0; i < 4; i++) begin
                tests++; if (reg_of(i) !== 8'(s_r[i])) begin fails++; $display("FAIL stall_r%0d got %0d want %0d", i, reg_of(i), s_r[i]); end
            end
            tests++; if (pc_out !== AW'(s_pc) || retire !== 1'b0) begin fails++; $display("FAIL stall_pc got %0d r%b want %0d r0", pc_out, retire, s_pc); end
            tests++; if (flag_z !== 1'(s_z) || flag_c !== 1'(s_c)) begin fails++; $display("FAIL stall_flags got z%b c%b want z%0d c%0d", flag_z, flag_c, s_z, s_c); end
        end
        run = 1'b1;
        run_until_halt(150);
        model_run(1000);
        want_hc = (m_hc <= 6) ? m_hc : m_hc + 5;
        for (int i = 0; i < 4; i++) begin
            tests++; if (reg_of(i) !== 8'(m_r[i])) begin fails++; $display("FAIL stall_final_r%0d got %0d want %0d", i, reg_of(i), m_r[i]); end
        end
        tests++; if (halt_at != want_hc || ret_cnt != m_n) begin fails++; $display("FAIL stall_timing got hc%0d n%0d want hc%0d n%0d", halt_at, ret_cnt, want_hc, m_n); end
    endtask

    task automatic test_random;
        repeat (4) begin
            gen_random;
            load_prog; release_core;
            run_until_halt(150);
            model_run(1000);
            for (int i = 0; i < 4; i++) begin
                tests++; if (reg_of(i) !== 8'(m_r[i])) begin fails++; $display("FAIL rand_r%0d got %0d want %0d", i, reg_of(i), m_r[i]); end
            end
            tests++; if (flag_z !== 1'(m_z) || flag_c !== 1'(m_c)) begin fails++; $display("FAIL rand_flags got z%b c%b want z%0d c%0d", flag_z, flag_c, m_z, m_c); end
            tests++; if (pc_out !== AW'(m_pc) || halted !== 1'b1) begin fails++; $display("FAIL rand_pc got %0d h%b want %0d h1", pc_out, halted, m_pc); end
            tests++; if (halt_at != m_hc || ret_cnt != m_n) begin fails++; $display("FAIL rand_timing got hc%0d n%0d want hc%0d n%0d", halt_at, ret_cnt, m_hc, m_n); end
        end
    endtask

    task automatic test_reset_jmp;
        fill_halt;
        prog[0] = enc(T_LDI, 0, 1);
        prog[1] = enc(T_LDI, 1, 2);
        prog[2] = enc(T_JMP, 0, 5);
        prog[3] = enc(T_LDI, 3, 9);
        prog[5] = enc(T_LDI, 2, 3);
        load_prog; release_core;
        repeat (3) tick;
        reset = 1'b1;
        tick;
        tests++; if (pc_out !== 5'd0 || regs_flat !== 32'd0 || retire !== 1'b0 || halted !== 1'b0) begin
            fails++; $display("FAIL rstjmp_state got pc%0d regs%h r%b want 0", pc_out, regs_flat, retire);
        end
        release_core;
        run_until_halt(40);
        model_run(1000);
        for (int i = 0; i < 4; i++) begin
            tests++; if (reg_of(i) !== 8'(m_r[i])) begin fails++; $display("FAIL rstjmp_r%0d got %0d want %0d", i, reg_of(i), m_r[i]); end
        end
        tests++; if (halt_at != m_hc || ret_cnt != m_n || pc_out !== AW'(m_pc)) begin
            fails++; $display("FAIL rstjmp_timing got hc%0d n%0d pc%0d want hc%0d n%0d pc%0d", halt_at, ret_cnt, pc_out, m_hc, m_n, m_pc);
        end
    endtask

    initial begin
        bus.imem_we    = 1'b0;
        bus.imem_addr  = '0;
        bus.imem_wdata = '0;
        test_reset;
        test_add_carry;
        test_bz;
        test_wrap;
        test_halt;
        test_run_stall;
        test_random;
        test_reset_jmp;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
